mips_multicycle_ctrl: RTL and testbench

//  Multi-cycle main controller for the MIPS ALU datapath: sequences fetch/decode/execute/mem/writeback
//  for R-type, lw, sw, beq, j, addi. Sits beside CONTROL/ALUControl, replacing the single-cycle decode;

---
 rtl/mips_ctrl_pkg.sv | 48 ++++
 rtl/mem_wait_timer.sv | 40 ++++
 rtl/mips_multicycle_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, FSM state encoding,
// and the datapath select codes driven on ALUOp / ALUSrcB / PCSource.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_R_WB     = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12,
    S_ERROR    = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that hold a memory request open until MEM_READY.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-stall watchdog: down-counter reloaded whenever no stall is in progress;
// flags timeout on the MEM_TIMEOUT-th consecutive stalled cycle (MEM_TIMEOUT=0 disables).
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_state,
  input  logic mem_ready,
  output logic timeout
);

  if (MEM_TIMEOUT == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = clk ^ rst_n ^ wait_state ^ mem_ready;
    assign timeout = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] remain;
    logic          stalled;

    assign stalled = wait_state && !mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        remain <= LOAD;
      end else if (!stalled) begin
        remain <= LOAD;
      end else if (remain != '0) begin
        remain <= remain - CW'(1);
      end
    end

    // A ready in the terminal cycle clears stalled, so normal advance wins.
    assign timeout = stalled && (remain == '0);
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main controller (Moore FSM) with memory-stall timeout and retired counter.
// Optional: define ILLEGAL_TRAP_EN to trap on unlisted opcodes instead of treating them as NOP.
//
//  state    | meaning
//  IDLE     | after reset, all outputs 0
//  FETCH    | read instruction at PC, PC+4 (IR/PC load on MEM_READY)
//  DECODE   | register read, branch target precompute
//  EXEC_R   | R-type ALU operation
//  R_WB     | write ALUOut to rd
//  MEM_ADDR | lw/sw effective address
//  MEM_RD   | data read, wait MEM_READY
//  MEM_WB   | write MDR to rt
//  MEM_WR   | data write, wait MEM_READY
//  BRANCH   | beq compare, PC load if Zero
//  JUMP     | PC load with jump target
//  ADDI_EX  | A + signext imm
//  ADDI_WB  | write ALUOut to rt
//  ERROR    | memory timeout, BUS_ERR held until reset
//  TRAP     | illegal opcode, TRAP held until reset
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_CNT_W = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [5:0]             opcode,
  input  logic                   Zero,
  input  logic                   MEM_READY,
  output logic                   PCWrite,
  output logic                   PCWriteCond,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   MemtoReg,
  output logic                   IRWrite,
  output logic                   RegDst,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             ALUOp,
  output logic [1:0]             PCSource,
  output logic                   BUS_ERR,
  output logic                   TRAP,
  output logic [INSTR_CNT_W-1:0] INSTR_RETIRED
);

  state_t                 state;
  state_t                 next_state;
  logic                   wait_state;
  logic                   timeout;
  logic                   retire;
  logic [INSTR_CNT_W-1:0] retired;

  // Zero is consumed by the datapath (PC enable = PCWrite | PCWriteCond & Zero).
  logic unused_zero;
  assign unused_zero = Zero;

  assign wait_state = is_wait_state(state);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .wait_state(wait_state),
    .mem_ready (MEM_READY),
    .timeout   (timeout)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    BUS_ERR     = 1'b0;
    TRAP        = 1'b0;

    case (state)
      S_IDLE: next_state = S_FETCH;

      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        IRWrite  = MEM_READY;
        PCWrite  = MEM_READY;
        if (timeout) begin
          next_state = S_ERROR;
        end else if (MEM_READY) begin
          next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH2;
        case (opcode)
          OP_RTYPE:     next_state = S_EXEC_R;
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_ADDI:      next_state = S_ADDI_EX;
`ifdef ILLEGAL_TRAP_EN
          default:      next_state = S_TRAP;
`else
          default:      next_state = S_FETCH;
`endif
        endcase
      end

      S_EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALUOP_FUNCT;
        next_state = S_R_WB;
      end

      S_R_WB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end

      S_MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (timeout) begin
          next_state = S_ERROR;
        end else if (MEM_READY) begin
          next_state = S_MEM_WB;
        end
      end

      S_MEM_WB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end

      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (timeout) begin
          next_state = S_ERROR;
        end else if (MEM_READY) begin
          next_state = S_FETCH;
        end
      end

      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        next_state  = S_FETCH;
      end

      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_JUMP;
        next_state = S_FETCH;
      end

      S_ADDI_EX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        next_state = S_ADDI_WB;
      end

      S_ADDI_WB: begin
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end

      S_ERROR: BUS_ERR = 1'b1;

      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        TRAP = 1'b1;
`endif
      end

      default: next_state = S_IDLE;
    endcase
  end

  // A stall in FETCH is not a new arrival, so FETCH->FETCH does not retire.
  assign retire = (next_state == S_FETCH) && (state != S_FETCH) && (state != S_IDLE);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      retired <= '0;
    end else if (retire && (retired != '1)) begin
      retired <= retired + INSTR_CNT_W'(1);
    end
  end

  assign INSTR_RETIRED = retired;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-cycle expected control vectors are queued
// as stimulus is planned and compared against the DUT as each cycle is applied.
module tb_mips_multicycle_ctrl;

  typedef enum {
    P_IDLE, P_FETCH, P_DECODE, P_EXEC_R, P_R_WB, P_MEM_ADDR, P_MEM_RD, P_MEM_WB,
    P_MEM_WR, P_BRANCH, P_JUMP, P_ADDI_EX, P_ADDI_WB, P_ERROR, P_TRAP
  } phase_t;

  typedef struct {
    phase_t      ph;
    logic        rdy;
    logic [5:0]  op;
    logic        zero;
    logic [31:0] ret;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        Zero = 1'b0;
  logic        MEM_READY = 1'b0;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic        RegDst, RegWrite, ALUSrcA, BUS_ERR, TRAP;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [31:0] INSTR_RETIRED;
  logic [17:0] obs;

  int     vectors = 0;
  int     miscompares = 0;
  exp_t   sb[$];
  logic [31:0] exp_ret;
  phase_t prev_ph;

  mips_multicycle_ctrl #(.INSTR_CNT_W(32), .MEM_TIMEOUT(15)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .opcode(opcode), .Zero(Zero), .MEM_READY(MEM_READY),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .BUS_ERR(BUS_ERR), .TRAP(TRAP), .INSTR_RETIRED(INSTR_RETIRED)
  );

  always #5 CLK = ~CLK;

  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, BUS_ERR, TRAP};

  // Expected control vector for a state, written from the controller's state table.
  function automatic logic [17:0] exp_vec(input phase_t ph, input logic rdy);
    logic pcw, pcwc, iord, mr, mw, m2r, irw, rdst, rw, srca, berr, trp;
    logic [1:0] srcb, aop, pcs;
    {pcw, pcwc, iord, mr, mw, m2r, irw, rdst, rw, srca, berr, trp} = '0;
    srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (ph)
      P_FETCH:    begin mr = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      P_DECODE:   srcb = 2'b11;
      P_EXEC_R:   begin srca = 1; aop = 2'b10; end
      P_R_WB:     begin rdst = 1; rw = 1; end
      P_MEM_ADDR: begin srca = 1; srcb = 2'b10; end
      P_MEM_RD:   begin mr = 1; iord = 1; end
      P_MEM_WB:   begin m2r = 1; rw = 1; end
      P_MEM_WR:   begin mw = 1; iord = 1; end
      P_BRANCH:   begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      P_JUMP:     begin pcw = 1; pcs = 2'b10; end
      P_ADDI_EX:  begin srca = 1; srcb = 2'b10; end
      P_ADDI_WB:  rw = 1;
      P_ERROR:    berr = 1;
      P_TRAP:     trp = 1;
      default:    ;
    endcase
    return {pcw, pcwc, iord, mr, mw, m2r, irw, rdst, rw, srca, srcb, aop, pcs, berr, trp};
  endfunction

  task automatic model_reset();
    exp_ret = 0;
    prev_ph = P_IDLE;
  endtask

  task automatic push_phase(input phase_t ph, input logic rdy, input logic [5:0] op,
                            input logic zero);
    exp_t e;
    if (ph == P_FETCH && prev_ph != P_FETCH && prev_ph != P_IDLE && exp_ret != 32'hFFFF_FFFF)
      exp_ret = exp_ret + 1;
    prev_ph = ph;
    e.ph = ph; e.rdy = rdy; e.op = op; e.zero = zero; e.ret = exp_ret;
    sb.push_back(e);
  endtask

  // Plans one instruction: fw stalled FETCH cycles, mw stalled data cycles.
  task automatic push_instr(input logic [5:0] op, input logic zero, input int fw, input int mw);
    for (int i = 0; i < fw; i++) push_phase(P_FETCH, 1'b0, op, zero);
    push_phase(P_FETCH, 1'b1, op, zero);
    push_phase(P_DECODE, 1'b1, op, zero);
    case (op)
      6'd0:  begin push_phase(P_EXEC_R, 1'b1, op, zero); push_phase(P_R_WB, 1'b1, op, zero); end
      6'd35: begin
        push_phase(P_MEM_ADDR, 1'b1, op, zero);
        for (int i = 0; i < mw; i++) push_phase(P_MEM_RD, 1'b0, op, zero);
        push_phase(P_MEM_RD, 1'b1, op, zero);
        push_phase(P_MEM_WB, 1'b1, op, zero);
      end
      6'd43: begin
        push_phase(P_MEM_ADDR, 1'b1, op, zero);
        for (int i = 0; i < mw; i++) push_phase(P_MEM_WR, 1'b0, op, zero);
        push_phase(P_MEM_WR, 1'b1, op, zero);
      end
      6'd4:  push_phase(P_BRANCH, 1'b1, op, zero);
      6'd2:  push_phase(P_JUMP, 1'b1, op, zero);
      6'd8:  begin push_phase(P_ADDI_EX, 1'b1, op, zero); push_phase(P_ADDI_WB, 1'b1, op, zero); end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) push_phase(P_TRAP, 1'b1, op, zero);
`endif
      end
    endcase
  endtask

  // Entered at posedge+1: apply one cycle's inputs, sample at the falling edge.
  task automatic cycle(input exp_t e, output logic [17:0] o, output logic [31:0] r);
    MEM_READY = e.rdy; opcode = e.op; Zero = e.zero;
    @(negedge CLK);
    o = obs;
    r = INSTR_RETIRED;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [17:0] o;
    logic [31:0] r;
    RESET_N = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    vectors++;
    if (obs !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want %b", obs, 18'd0);
    end
    vectors++;
    if (INSTR_RETIRED !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_retired: got %0d want 0", INSTR_RETIRED);
    end
    RESET_N = 1'b1;
    model_reset();
    push_phase(P_IDLE, 1'b1, 6'd0, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cycle(e, o, r);
      vectors++;
      if (o !== exp_vec(e.ph, e.rdy) || r !== e.ret) begin
        miscompares++;
        $display("FAIL reset_release %s: got %b/%0d want %b/%0d", e.ph.name(), o, r,
                 exp_vec(e.ph, e.rdy), e.ret);
      end
    end
  endtask

  task automatic test_rtype();
    exp_t e;
    logic [17:0] o;
    logic [31:0] r;
    push_instr(6'd0, 1'b0, 0, 0);
    push_instr(6'd0, 1'b0, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cycle(e, o, r);
      vectors++;
      if (o !== exp_vec(e.ph, e.rdy) || r !== e.ret) begin
        miscompares++;
        $display("FAIL rtype %s: got %b/%0d want %b/%0d", e.ph.name(), o, r,
                 exp_vec(e.ph, e.rdy), e.ret);
      end
    end
  endtask

  task automatic test_mem_wait();
    exp_t e;
    logic [17:0] o;
    logic [31:0] r;
    push_instr(6'd35, 1'b0, 0, 3);
    push_instr(6'd35, 1'b0, 2, 0);
    push_instr(6'd43, 1'b0, 0, 0);
    push_instr(6'd43, 1'b0, 1, 4);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cycle(e, o, r);
      vectors++;
      if (o !== exp_vec(e.ph, e.rdy) || r !== e.ret) begin
        miscompares++;
        $display("FAIL mem_wait %s: got %b/%0d want %b/%0d", e.ph.name(), o, r,
                 exp_vec(e.ph, e.rdy), e.ret);
      end
    end
  endtask

  task automatic test_branch_jump();
    exp_t e;
    logic [17:0] o;
    logic [31:0] r;
    push_instr(6'd4, 1'b1, 0, 0);
    push_instr(6'd4, 1'b0, 0, 0);
    push_instr(6'd2, 1'b0, 0, 0);
    push_instr(6'd8, 1'b0, 0, 0);
    push_instr(6'd2, 1'b1, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cycle(e, o, r);
      vectors++;
      if (o !== exp_vec(e.ph, e.rdy) || r !== e.ret) begin
        miscompares++;
        $display("FAIL branch_jump %s: got %b/%0d want %b/%0d", e.ph.name(), o, r,
                 exp_vec(e.ph, e.rdy), e.ret);
      end
    end
  endtask

  task automatic test_timeout_recover();
    exp_t e;
    logic [17:0] o;
    logic [31:0] r;
    push_instr(6'd0, 1'b0, 14, 0);
    push_instr(6'd35, 1'b0, 0, 14);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cycle(e, o, r);
      vectors++;
      if (o !== exp_vec(e.ph, e.rdy) || r !== e.ret) begin
        miscompares++;
        $display("FAIL timeout_recover %s: got %b/%0d want %b/%0d", e.ph.name(), o, r,
                 exp_vec(e.ph, e.rdy), e.ret);
      end
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    logic [17:0] o;
    logic [31:0] r;
    push_instr(6'd63, 1'b0, 0, 0);
    push_instr(6'd0, 1'b0, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cycle(e, o, r);
      vectors++;
      if (o !== exp_vec(e.ph, e.rdy) || r !== e.ret) begin
        miscompares++;
        $display("FAIL illegal %s: got %b/%0d want %b/%0d", e.ph.name(), o, r,
                 exp_vec(e.ph, e.rdy), e.ret);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    logic [17:0] o;
    logic [31:0] r;
    RESET_N = 1'b0;
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    model_reset();
    push_phase(P_IDLE, 1'b1, 6'd0, 1'b0);
    push_instr(6'd8, 1'b0, 0, 0);
    push_phase(P_FETCH, 1'b1, 6'd0, 1'b0);
    push_phase(P_DECODE, 1'b1, 6'd0, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cycle(e, o, r);
      vectors++;
      if (o !== exp_vec(e.ph, e.rdy) || r !== e.ret) begin
        miscompares++;
        $display("FAIL mid_reset_pre %s: got %b/%0d want %b/%0d", e.ph.name(), o, r,
                 exp_vec(e.ph, e.rdy), e.ret);
      end
    end
    MEM_READY = 1'b1; opcode = 6'd0;
    #2;
    vectors++;
    if (obs !== exp_vec(P_EXEC_R, 1'b1) || INSTR_RETIRED !== 32'd1) begin
      miscompares++;
      $display("FAIL mid_reset_exec: got %b/%0d want %b/1", obs, INSTR_RETIRED,
               exp_vec(P_EXEC_R, 1'b1));
    end
    RESET_N = 1'b0;
    #1;
    vectors++;
    if (obs !== 18'd0 || INSTR_RETIRED !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_reset_async: got %b/%0d want %b/0", obs, INSTR_RETIRED, 18'd0);
    end
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    model_reset();
    push_phase(P_IDLE, 1'b1, 6'd0, 1'b0);
    push_instr(6'd0, 1'b0, 0, 0);
    push_instr(6'd2, 1'b0, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cycle(e, o, r);
      vectors++;
      if (o !== exp_vec(e.ph, e.rdy) || r !== e.ret) begin
        miscompares++;
        $display("FAIL mid_reset_post %s: got %b/%0d want %b/%0d", e.ph.name(), o, r,
                 exp_vec(e.ph, e.rdy), e.ret);
      end
    end
  endtask

  task automatic test_timeout_error();
    exp_t e;
    logic [17:0] o;
    logic [31:0] r;
    for (int i = 0; i < 15; i++) push_phase(P_FETCH, 1'b0, 6'd0, 1'b0);
    for (int i = 0; i < 4; i++) push_phase(P_ERROR, i[0], 6'd0, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cycle(e, o, r);
      vectors++;
      if (o !== exp_vec(e.ph, e.rdy) || r !== e.ret) begin
        miscompares++;
        $display("FAIL timeout_error %s: got %b/%0d want %b/%0d", e.ph.name(), o, r,
                 exp_vec(e.ph, e.rdy), e.ret);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rtype();
    test_mem_wait();
    test_branch_jump();
    test_timeout_recover();
    test_illegal();
    test_mid_reset();
    test_timeout_error();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got stuck want finished");
    $fatal(1, "watchdog");
  end

endmodule
